serial_rx_sampler: RTL and testbench

Receive-side block for the asynchronous serial bit line. It synchronises the incoming `rxd` to `clk`, detects a start bit, samples `DATA_W` data bits LSB-first at mid-bit, checks the stop bit, and presents the byte with a one-cycle `valid` strobe. It is the receiving end of the single-wire serial interface and is fed by a free-running line that is asynchronous to `clk`.

---
 rtl/serial_rx_sampler.sv | 103 ++++++++++
 tb/tb_serial_rx_sampler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_rx_sampler.sv
// serial_rx_sampler: asynchronous serial receiver with 2-flop synchroniser, mid-bit sampling and stop/parity checks
// Ports: clk (rising edge), rst (asynchronous, active-high), rxd (asynchronous line, idle high)
//        data (last good word), valid / frame_err / parity_err (one-cycle strobes), busy (FSM not in IDLE)
// Macro SERIAL_RX_PARITY_EN compiles in one even-parity bit after the data bits; undefined ties parity_err to 0.
module serial_rx_sampler #(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W + 1);
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;
`ifdef SERIAL_RX_PARITY_EN
  localparam state_t S_AFTER_DATA = S_PARITY;
`else
  localparam state_t S_AFTER_DATA = S_STOP;
`endif
  state_t            r_state, w_next;
  logic              r_rxd_s1, r_rxd_s2, r_rxd_d;
  logic [CW-1:0]     r_cyc;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
`ifdef SERIAL_RX_PARITY_EN
  logic              r_pbit;
`endif
  logic              w_fall, w_tick, w_last, w_stop, w_valid, w_ferr, w_perr;
  assign w_fall = r_rxd_d & ~r_rxd_s2;
  // The start check lands half a bit after T0; every later sample is one full bit after the previous one.
  assign w_tick = r_cyc == ((r_state == S_START) ? CW'(CLK_DIV / 2 - 1) : CW'(CLK_DIV - 1));
  assign w_last = r_bit == BW'(DATA_W - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START:  if (w_tick) w_next = r_rxd_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (w_tick && w_last) w_next = S_AFTER_DATA;
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: if (w_tick) w_next = S_STOP;
`endif
      S_STOP:   if (w_tick) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  always_comb begin
    busy    = r_state != S_IDLE;
    w_stop  = (r_state == S_STOP) && w_tick;
    w_ferr  = w_stop && !r_rxd_s2;
`ifdef SERIAL_RX_PARITY_EN
    w_perr  = w_stop && (^r_shift ^ r_pbit);
`else
    w_perr  = 1'b0;
`endif
    w_valid = w_stop && r_rxd_s2 && !w_perr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_d    <= 1'b1;
      r_cyc      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
`ifdef SERIAL_RX_PARITY_EN
      r_pbit     <= 1'b0;
`endif
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      {r_rxd_d, r_rxd_s2, r_rxd_s1} <= {r_rxd_s2, r_rxd_s1, rxd};
      r_cyc <= (r_state == S_IDLE || w_tick) ? '0 : r_cyc + 1'b1;
      r_bit <= (r_state == S_IDLE) ? '0 : r_bit + BW'(r_state == S_DATA && w_tick);
      // Shift in from the top so the first data bit ends up in bit 0.
      if (r_state == S_DATA && w_tick) r_shift <= DATA_W'({r_rxd_s2, r_shift} >> 1);
`ifdef SERIAL_RX_PARITY_EN
      if (r_state == S_PARITY && w_tick) r_pbit <= r_rxd_s2;
`endif
      if (w_valid) data <= r_shift;
      valid      <= w_valid;
      frame_err  <= w_ferr;
      parity_err <= w_perr;
    end
endmodule

// File: tb/tb_serial_rx_sampler.sv
// tb_serial_rx_sampler: scoreboard bench for serial_rx_sampler with directed and random frames
module tb_serial_rx_sampler;
  localparam int DIV = 16;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int LAT = 2 + 169;
`else
  localparam bit PAR = 1'b0;
  localparam int LAT = 2 + 153;
`endif
  typedef struct {
    logic       v, fe, pe;
    logic [7:0] d;
    int         cyc;
  } exp_t;
  logic       clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;
  int         cyc = 0, checks = 0, errors = 0, k;
  logic [7:0] last_good = 8'h00;
  exp_t       q[$];
  exp_t       e;
  serial_rx_sampler dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic send_frame(input logic [7:0] w, input bit stop, input bit pf, input int stop_len);
    exp_t x;
    x.fe  = !stop;
    x.pe  = PAR && pf;
    x.v   = stop && !x.pe;
    if (x.v) last_good = w;
    x.d   = last_good;
    x.cyc = cyc + LAT;
    q.push_back(x);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = w[i];
      repeat (DIV) @(negedge clk);
    end
    if (PAR) begin
      rxd = ^w ^ pf;
      repeat (DIV) @(negedge clk);
    end
    rxd = stop;
    repeat (stop_len) @(negedge clk);
  endtask
  always @(negedge clk)
    if (valid || frame_err || parity_err) begin
      if (q.size() == 0) chk("unexpected_strobe", {valid, frame_err, parity_err}, 3'b000);
      else begin
        e = q.pop_front();
        chk("strobe_flags", {valid, frame_err, parity_err}, {e.v, e.fe, e.pe});
        chk("strobe_data", data, e.d);
        chk("strobe_cycle", cyc, e.cyc);
        chk("busy_at_strobe", busy, 1'b0);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_parity_err", parity_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, DIV);
    repeat (20) @(negedge clk);
    chk("good_data", data, 8'hA5);
    k = cyc;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    chk("glitch_busy_high", busy, 1'b1);
    repeat (7) @(negedge clk);
    chk("glitch_busy_by_t0p9", busy, 1'b0);
    chk("glitch_cycle", cyc, k + 11);
    repeat (20) @(negedge clk);
    chk("glitch_data", data, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0, DIV);
    repeat (200) @(negedge clk);
    chk("break_busy", busy, 1'b0);
    chk("break_data", data, 8'hA5);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    chk("midframe_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midframe_rst_data", data, 8'h00);
    chk("midframe_rst_busy", busy, 1'b0);
    last_good = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", busy, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0, DIV);
    send_frame(8'hFF, 1'b1, 1'b0, DIV);
    repeat (20) @(negedge clk);
    chk("b2b_data", data, 8'hFF);
`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, DIV);
    send_frame(8'h07, 1'b1, 1'b1, DIV);
    send_frame(8'h07, 1'b0, 1'b1, DIV);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
`endif
    for (int n = 0; n < 24; n++) begin
      logic [7:0] w;
      bit stop, pf;
      w    = 8'($urandom);
      stop = $urandom_range(0, 4) != 0;
      pf   = PAR && ($urandom_range(0, 3) == 0);
      send_frame(w, stop, pf, DIV);
      rxd = 1'b1;
      if (!stop) repeat (20) @(negedge clk);
      else repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    chk("final_data", data, last_good);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
